// File: rtl/piezo_sound_sequencer.sv
// Piezo buzzer sequencer: turns game sound commands into timed square-wave tones.
// Handles priority preemption, a single pending slot and a three-note GAME OVER tune.
module piezo_sound_sequencer #(
    parameter int TICK_DIV  = 50000,
    parameter int HIT_HALF  = 25000,
    parameter int MISS_HALF = 62500,
    parameter int OVR_HALF0 = 47801,
    parameter int OVR_HALF1 = 63776,
    parameter int OVR_HALF2 = 95420,
    parameter int HIT_MS    = 50,
    parameter int MISS_MS   = 150,
    parameter int NOTE_MS   = 200,
    parameter int GAP_MS    = 10
) (
    input  logic       i_Clk,
    input  logic       i_Rst,
    input  logic [1:0] i_Sound_Cmd,
    input  logic       i_Mute,
    output logic       o_Piezo,
    output logic       o_Busy,
    output logic [1:0] o_Cur_Cmd
);

    localparam logic [15:0] TICK_M1 = 16'(TICK_DIV - 1);
    localparam logic [16:0] HIT_M1  = 17'(HIT_HALF - 1);
    localparam logic [16:0] MISS_M1 = 17'(MISS_HALF - 1);
    localparam logic [16:0] OVR0_M1 = 17'(OVR_HALF0 - 1);
    localparam logic [16:0] OVR1_M1 = 17'(OVR_HALF1 - 1);
    localparam logic [16:0] OVR2_M1 = 17'(OVR_HALF2 - 1);
    localparam logic [7:0]  HIT_D   = 8'(HIT_MS - 1);
    localparam logic [7:0]  MISS_D  = 8'(MISS_MS - 1);
    localparam logic [7:0]  NOTE_D  = 8'(NOTE_MS - 1);
    localparam logic [7:0]  GAP_D   = 8'(GAP_MS - 1);

    typedef enum logic [1:0] {
        IDLE,
        PLAY,
        GAP
    } state_t;

    state_t      state;
    logic [1:0]  prev_cmd;
    logic [1:0]  pending;
    logic [1:0]  note_idx;
    logic [16:0] phase_cnt;
    logic [15:0] tick_cnt;
    logic [7:0]  ms_cnt;
    logic        tone;

    logic [1:0]  req;
    logic [16:0] half_m1;
    logic [7:0]  dur_m1;
    logic        tick_end;
    logic        note_end;
    logic        gap_end;
    logic        go;
    logic [1:0]  go_cmd;
    logic [1:0]  idle_pend;

    // A request is a nonzero command that differs from last cycle's command
    always_comb begin
        req = 2'd0;
        if (i_Sound_Cmd != 2'd0 && i_Sound_Cmd != prev_cmd) begin
            req = i_Sound_Cmd;
        end
    end

    // Half-period and note length of whatever is sounding now
    always_comb begin
        half_m1 = HIT_M1;
        dur_m1  = HIT_D;
        case (o_Cur_Cmd)
            2'd2: begin
                half_m1 = MISS_M1;
                dur_m1  = MISS_D;
            end
            2'd3: begin
                dur_m1 = NOTE_D;
                case (note_idx)
                    2'd0:    half_m1 = OVR0_M1;
                    2'd1:    half_m1 = OVR1_M1;
                    default: half_m1 = OVR2_M1;
                endcase
            end
            default: ;
        endcase
    end

    assign tick_end = (tick_cnt == TICK_M1);
    assign note_end = tick_end && (ms_cnt == dur_m1);
    assign gap_end  = tick_end && (ms_cnt == GAP_D);

    // Decide whether a sound (re)starts this cycle and what pending becomes in IDLE
    always_comb begin
        go        = 1'b0;
        go_cmd    = 2'd0;
        idle_pend = pending;
        if (state == IDLE) begin
            if (req >= pending) begin
                go_cmd = req;
            end else begin
                go_cmd    = pending;
                idle_pend = req;
            end
            go = (go_cmd != 2'd0);
        end else if (req != 2'd0 && req >= o_Cur_Cmd) begin
            go     = 1'b1;
            go_cmd = req;
        end
    end

    // Sequencer state, timing counters and registered outputs
    always_ff @(posedge i_Clk or negedge i_Rst) begin
        if (!i_Rst) begin
            state     <= IDLE;
            prev_cmd  <= 2'd0;
            pending   <= 2'd0;
            note_idx  <= 2'd0;
            phase_cnt <= 17'd0;
            tick_cnt  <= 16'd0;
            ms_cnt    <= 8'd0;
            tone      <= 1'b0;
            o_Piezo   <= 1'b0;
            o_Busy    <= 1'b0;
            o_Cur_Cmd <= 2'd0;
        end else begin
            prev_cmd <= i_Sound_Cmd;
            if (go) begin
                state     <= PLAY;
                o_Cur_Cmd <= go_cmd;
                o_Busy    <= 1'b1;
                note_idx  <= 2'd0;
                phase_cnt <= 17'd0;
                tick_cnt  <= 16'd0;
                ms_cnt    <= 8'd0;
                tone      <= 1'b0;
                o_Piezo   <= 1'b0;
                if (state == IDLE) begin
                    pending <= idle_pend;
                end
            end else begin
                if (state != IDLE && req > pending) begin
                    pending <= req;
                end
                case (state)
                    PLAY: begin
                        if (note_end) begin
                            phase_cnt <= 17'd0;
                            tick_cnt  <= 16'd0;
                            ms_cnt    <= 8'd0;
                            tone      <= 1'b0;
                            o_Piezo   <= 1'b0;
                            if (o_Cur_Cmd == 2'd3 && note_idx < 2'd2) begin
                                state <= GAP;
                            end else begin
                                state     <= IDLE;
                                o_Busy    <= 1'b0;
                                o_Cur_Cmd <= 2'd0;
                            end
                        end else begin
                            tick_cnt <= tick_end ? 16'd0 : tick_cnt + 16'd1;
                            ms_cnt   <= ms_cnt + 8'(tick_end);
                            if (phase_cnt == half_m1) begin
                                phase_cnt <= 17'd0;
                                tone      <= ~tone;
                                o_Piezo   <= ~tone & ~i_Mute;
                            end else begin
                                phase_cnt <= phase_cnt + 17'd1;
                                o_Piezo   <= tone & ~i_Mute;
                            end
                        end
                    end
                    GAP: begin
                        o_Piezo <= 1'b0;
                        tone    <= 1'b0;
                        if (gap_end) begin
                            state     <= PLAY;
                            note_idx  <= note_idx + 2'd1;
                            phase_cnt <= 17'd0;
                            tick_cnt  <= 16'd0;
                            ms_cnt    <= 8'd0;
                        end else begin
                            tick_cnt <= tick_end ? 16'd0 : tick_cnt + 16'd1;
                            ms_cnt   <= ms_cnt + 8'(tick_end);
                        end
                    end
                    default: begin
                        tone    <= 1'b0;
                        o_Piezo <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
